aes_column_accum: RTL and testbench

AES_COLUMN_ACCUM -- requirements
Module: aes_column_accum

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_column_mix.sv | 32 +++
 rtl/aes_column_accum.sv | 100 ++++++++++
 tb/tb_aes_column_accum.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg
// Shared types and constants for the AES column accumulator.
//   NUM_COLS      : number of 32-bit columns in one 128-bit AES state
//   lookup_word_t : per-row lookup word, bits [0:7] S-box byte,
//                   bits [8:39] row-rotated T-box word
//   column_t      : one 32-bit state column
//   state_t       : full 128-bit state, column c at bits [32c:32c+31]
//   fsm_state_t   : accumulator FSM states
package aes_pkg;

    localparam int NUM_COLS = 4;

    typedef logic [0:39]  lookup_word_t;
    typedef logic [0:31]  column_t;
    typedef logic [0:127] state_t;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/aes_column_mix.sv
// aes_column_mix
// Combinational column combiner for one AES round column.
// Ports:
//   words  : in  4 x 40  per-row lookup words (S-box byte + rotated T-box word)
//   key    : in  32      round-key word for this column
//   last   : in  1       final round: take S-box bytes instead of T-box sum
//   column : out 32      resulting state column
module aes_column_mix
    import aes_pkg::*;
(
    input  lookup_word_t [0:3] words,
    input  logic [0:31]        key,
    input  logic               last,
    output logic [0:31]        column
);

    column_t t_sum;
    column_t s_bytes;

    // A normal round XORs the four row-rotated T-box words, which already
    // folds SubBytes, ShiftRows and MixColumns together. The final round
    // skips MixColumns, so only the raw S-box bytes are packed row by row.
    always_comb begin
        t_sum = '0;
        for (int r = 0; r < NUM_COLS; r++) begin
            t_sum = t_sum ^ words[r][8:39];
        end
        s_bytes = {words[0][0:7], words[1][0:7], words[2][0:7], words[3][0:7]};
        column  = (last ? s_bytes : t_sum) ^ key;
    end

endmodule

// File: rtl/aes_column_accum.sv
// aes_column_accum
// Collects four round columns into a 128-bit AES state and hands the
// completed state downstream with valid/ready handshakes on both sides.
// Ports:
//   clk       : in  1        rising-edge clock
//   rst       : in  1        synchronous active-high reset
//   in_valid  : in  1        column beat offered
//   in_ready  : out 1        column beat accepted when in_valid && in_ready
//   in_words  : in  4 x 40   per-row lookup words for this column
//   in_key    : in  32       round-key word for this column
//   in_last   : in  1        beat belongs to the final round
//   out_valid : out 1        full state available
//   out_ready : in  1        consumer accepts the state
//   out_state : out 128      assembled state, column c at bits [32c:32c+31]
//   out_last  : out 1        in_last of the beat that completed the state
module aes_column_accum
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:3][0:39]  in_words,
    input  logic [0:31]       in_key,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:127]      out_state,
    output logic              out_last
);

    localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

    fsm_state_t state;
    logic [1:0] col_cnt;
    column_t    slots [NUM_COLS];
    column_t    mix_column;
    logic       accept;

    aes_column_mix u_mix (
        .words  (in_words),
        .key    (in_key),
        .last   (in_last),
        .column (mix_column)
    );

    // While FULL, a new beat can only enter in the same cycle the pending
    // state leaves, so input readiness follows the consumer directly.
    assign out_valid = (state == FULL);
    assign in_ready  = (state == COLLECT) || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_state = {slots[0], slots[1], slots[2], slots[3]};

    // Reset wins over any handshake in the same cycle and discards both a
    // partial block and a pending full state. A handshake in FULL delivers
    // the state and writes the incoming beat as column 0 of the next block,
    // so a continuous stream runs without bubbles. Slots are never cleared
    // between blocks; each is overwritten before the next delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= COLLECT;
            col_cnt  <= 2'd0;
            out_last <= 1'b0;
            for (int i = 0; i < NUM_COLS; i++) begin
                slots[i] <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        slots[col_cnt] <= mix_column;
                        if (col_cnt == LAST_COL) begin
                            state    <= FULL;
                            col_cnt  <= 2'd0;
                            out_last <= in_last;
                        end else begin
                            col_cnt <= col_cnt + 2'd1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state <= COLLECT;
                        if (in_valid) begin
                            slots[0] <= mix_column;
                            col_cnt  <= 2'd1;
                        end else begin
                            col_cnt <= 2'd0;
                        end
                    end
                end
                default: begin
                    state   <= COLLECT;
                    col_cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_column_accum.sv
// tb_aes_column_accum
// Self-checking bench for aes_column_accum: directed vectors with
// hand-computed states, plus a streaming scoreboard for long runs.
module tb_aes_column_accum;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [0:3][0:39] in_words;
    logic [0:31]      in_key;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [0:127]     out_state;
    logic             out_last;

    typedef struct {
        logic [0:127] blkState;
        logic         blkLast;
    } block_t;

    localparam logic [0:3][0:39] W_ZERO = {40'h63c66363a5, 40'h63a5c66363,
                                           40'h6363a5c663, 40'h636363a5c6};
    localparam logic [0:3][0:39] W_A    = {40'h1100000001, 40'h2200000010,
                                           40'h3300000100, 40'h4400001000};
    localparam logic [0:3][0:39] W_F    = {4{40'hffffffffff}};

    localparam logic [127:0] EXP_ZERO_NORMAL = {4{32'h63636363}};
    localparam logic [127:0] EXP_ZERO_LAST   = {4{32'h62616067}};
    localparam logic [127:0] EXP_MIXED       = {32'hA0001111, 32'hA1223344,
                                                32'hC0001111, 32'hD0001111};

    int compareCount  = 0;
    int mismatchCount = 0;
    int stallCount    = 0;
    int cycleCount    = 0;

    logic         sbEnable = 1'b0;
    block_t       expQ [$];
    int           deliveryCycles [$];
    logic [0:127] modelState;
    int           mcnt = 0;
    int           acceptedCount = 0;
    int           deliveredCount = 0;
    logic         prevStalled = 1'b0;
    logic [0:127] heldState;
    logic         heldLast;

    aes_column_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_words  (in_words),
        .in_key    (in_key),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_last  (out_last)
    );

    // Free-running clock, period 10.
    initial forever #5 clk = ~clk;

    // Cycle counter used to measure spacing between deliveries.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Hard stop in case something above loses its own bound.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference column straight from the round definition.
    function automatic logic [31:0] refColumn(input logic [0:3][0:39] w,
                                              input logic [31:0] k, input logic l);
        logic [31:0] acc;
        if (l) acc = {w[0][0:7], w[1][0:7], w[2][0:7], w[3][0:7]};
        else   acc = w[0][8:39] ^ w[1][8:39] ^ w[2][8:39] ^ w[3][8:39];
        return acc ^ k;
    endfunction

    task automatic applyStimulus(input logic v, input logic [0:3][0:39] w,
                                 input logic [31:0] k, input logic l);
        in_valid = v;
        in_words = w;
        in_key   = k;
        in_last  = l;
    endtask

    // Offers one beat and returns on the falling edge after it was taken.
    task automatic sendBeat(input logic [0:3][0:39] w, input logic [31:0] k,
                            input logic l);
        int waitCycles;
        waitCycles = 0;
        applyStimulus(1'b1, w, k, l);
        #1;
        while (!in_ready && waitCycles < 50) begin
            @(negedge clk);
            #1;
            waitCycles++;
        end
        stallCount += waitCycles;
        if (!in_ready) checkOutput("beat_timeout", 128'(in_ready), 128'(1));
        @(negedge clk);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [0:3][0:39] randWords();
        logic [0:3][0:39] w;
        for (int r = 0; r < 4; r++) w[r] = {8'($urandom), 32'($urandom)};
        return w;
    endfunction

    // Scoreboard: sampled just after the falling edge, so every handshake
    // seen here completes on the following rising edge. Expected blocks are
    // built from accepted beats; delivered states are checked against them,
    // and a stalled state must hold until it is taken.
    always @(negedge clk) begin
        #1;
        if (sbEnable && !rst) begin
            if (prevStalled && out_valid) begin
                checkOutput("hold_state", 128'(out_state), 128'(heldState));
                checkOutput("hold_last", 128'(out_last), 128'(heldLast));
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("sb_unexpected_block", 128'(1), 128'(0));
                end else begin
                    block_t e;
                    e = expQ.pop_front();
                    checkOutput("sb_state", 128'(out_state), 128'(e.blkState));
                    checkOutput("sb_last", 128'(out_last), 128'(e.blkLast));
                end
                deliveredCount++;
                deliveryCycles.push_back(cycleCount);
            end
            prevStalled = out_valid && !out_ready;
            heldState   = out_state;
            heldLast    = out_last;
            if (in_valid && in_ready) begin
                modelState[32*mcnt +: 32] = refColumn(in_words, in_key, in_last);
                mcnt++;
                acceptedCount++;
                if (mcnt == 4) begin
                    expQ.push_back('{modelState, in_last});
                    mcnt = 0;
                end
            end
        end else begin
            prevStalled    = 1'b0;
            mcnt           = 0;
            acceptedCount  = 0;
            deliveredCount = 0;
            expQ.delete();
            deliveryCycles.delete();
        end
    end

    initial begin
        int guard;
        rst       = 1'b1;
        out_ready = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
        checkOutput("reset_out_state", 128'(out_state), 128'(0));
        checkOutput("reset_out_last", 128'(out_last), 128'(0));
        checkOutput("reset_in_ready", 128'(in_ready), 128'(1));
        rst = 1'b0;

        // Byte 0x00 columns, normal round, zero key; state appears right
        // after the fourth beat and not before.
        for (int i = 0; i < 4; i++) begin
            sendBeat(W_ZERO, 32'h0, 1'b0);
            if (i < 3) checkOutput("early_out_valid", 128'(out_valid), 128'(0));
        end
        applyStimulus(1'b1, W_F, 32'hffffffff, 1'b1);
        #1;
        checkOutput("zero_out_valid", 128'(out_valid), 128'(1));
        checkOutput("zero_out_state", 128'(out_state), EXP_ZERO_NORMAL);
        checkOutput("zero_out_last", 128'(out_last), 128'(0));

        // Back-pressure for five cycles with a beat offered meanwhile.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checkOutput("stall_out_valid", 128'(out_valid), 128'(1));
            checkOutput("stall_out_state", 128'(out_state), EXP_ZERO_NORMAL);
            checkOutput("stall_in_ready", 128'(in_ready), 128'(0));
        end

        // Release with a beat waiting: it becomes column 0 of a last-round
        // block, so three more beats must complete it.
        out_ready = 1'b1;
        sendBeat(W_ZERO, 32'h01020304, 1'b1);
        out_ready = 1'b0;
        checkOutput("release_out_valid", 128'(out_valid), 128'(0));
        for (int i = 0; i < 3; i++) sendBeat(W_ZERO, 32'h01020304, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("last_out_valid", 128'(out_valid), 128'(1));
        checkOutput("last_out_state", 128'(out_state), EXP_ZERO_LAST);
        checkOutput("last_out_last", 128'(out_last), 128'(1));

        // Reset while FULL drops the pending state; readiness comes back
        // only after the reset edge.
        rst = 1'b1;
        #1;
        checkOutput("full_reset_in_ready_before", 128'(in_ready), 128'(0));
        @(negedge clk);
        #1;
        checkOutput("full_reset_out_valid", 128'(out_valid), 128'(0));
        checkOutput("full_reset_out_state", 128'(out_state), 128'(0));
        checkOutput("full_reset_out_last", 128'(out_last), 128'(0));
        checkOutput("full_reset_in_ready_after", 128'(in_ready), 128'(1));
        rst = 1'b0;

        // Two beats, then reset with another beat offered; the following
        // four beats (mixed modes) must form the block on their own.
        @(negedge clk);
        sendBeat(W_F, 32'hffffffff, 1'b0);
        sendBeat(W_F, 32'hffffffff, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_reset_out_valid", 128'(out_valid), 128'(0));
        checkOutput("mid_reset_out_state", 128'(out_state), 128'(0));
        sendBeat(W_A, 32'hA0000000, 1'b0);
        sendBeat(W_A, 32'hB0000000, 1'b1);
        sendBeat(W_A, 32'hC0000000, 1'b0);
        sendBeat(W_A, 32'hD0000000, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("mixed_out_valid", 128'(out_valid), 128'(1));
        checkOutput("mixed_out_state", 128'(out_state), EXP_MIXED);
        checkOutput("mixed_out_last", 128'(out_last), 128'(0));
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("mixed_drained", 128'(out_valid), 128'(0));

        // Three back-to-back blocks with the consumer always ready.
        resetDut();
        sbEnable   = 1'b1;
        out_ready  = 1'b1;
        stallCount = 0;
        for (int i = 0; i < 12; i++) sendBeat(randWords(), 32'($urandom), 1'($urandom));
        applyStimulus(1'b0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        checkOutput("stream_stalls", 128'(stallCount), 128'(0));
        checkOutput("stream_accepted", 128'(acceptedCount), 128'(12));
        checkOutput("stream_blocks", 128'(deliveredCount), 128'(3));
        if (deliveryCycles.size() == 3) begin
            checkOutput("stream_gap0", 128'(deliveryCycles[1] - deliveryCycles[0]), 128'(4));
            checkOutput("stream_gap1", 128'(deliveryCycles[2] - deliveryCycles[1]), 128'(4));
        end
        sbEnable = 1'b0;

        // Random valid/ready/last traffic for 1000 accepted beats.
        resetDut();
        @(negedge clk);
        sbEnable = 1'b1;
        guard    = 0;
        while (acceptedCount < 1000 && guard < 20000) begin
            @(negedge clk);
            applyStimulus(1'($urandom_range(0, 1)), randWords(), 32'($urandom),
                          1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 3) != 0);
            guard++;
        end
        applyStimulus(1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checkOutput("rand_timeout", 128'(guard < 20000), 128'(1));
        checkOutput("rand_accepted", 128'(acceptedCount), 128'(1000));
        checkOutput("rand_blocks", 128'(deliveredCount), 128'(250));
        checkOutput("rand_queue_empty", 128'(expQ.size()), 128'(0));
        sbEnable = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
